instr_fetch_unit: RTL

Prefetching instruction fetch unit that sits directly upstream of the single-cycle core. It issues sequential fetch requests to instruction memory over a request/grant + response handshake. It buffers returned words in a small in-order queue and presents them to the core as an instruction word, address and valid, consumed with a ready signal. A redirect input flushes the queue, discards in-flight responses and restarts fetch at a new address.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: credit-limited sequential fetch into an in-order queue.
// Build option IFU_BYPASS_EN forwards a response straight to the core when the queue is empty.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] op_instr,
  output logic [31:0] op_instr_addr,
  output logic        op_instr_valid,
  input  logic        ip_instr_ready,
  input  logic        ip_redirect,
  input  logic [31:0] ip_redirect_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      addr_q [DEPTH];

  logic [31:0]      redirect_pc;
  logic [CNT_W:0]   credit_used;
  logic             grant, drop, push, pop, bypass;

  assign redirect_pc = ip_redirect_addr & 32'hFFFF_FFFC;
  assign imem_addr   = fetch_pc_q;

  // Credits cover both in-flight fetches and buffered words, so a granted fetch always has a slot.
  always_comb begin
    credit_used = {1'b0, outst_q} + {1'b0, count_q};
    imem_req    = (state_q == ST_RUN) && !ip_redirect && (credit_used < DEPTH_C);
    grant       = imem_req && imem_gnt;
    drop        = imem_rvalid && (discard_q != '0);
`ifdef IFU_BYPASS_EN
    bypass      = imem_rvalid && !drop && !ip_redirect && (count_q == '0);
`else
    bypass      = 1'b0;
`endif
    push        = imem_rvalid && !drop && !ip_redirect && !(bypass && ip_instr_ready);
    pop         = (count_q != '0) && ip_instr_ready && !ip_redirect;
  end

  always_comb begin
    op_instr       = data_q[rd_ptr_q];
    op_instr_addr  = addr_q[rd_ptr_q];
    op_instr_valid = (count_q != '0);
`ifdef IFU_BYPASS_EN
    if (bypass) begin
      op_instr       = imem_rdata;
      op_instr_addr  = resp_pc_q;
      op_instr_valid = 1'b1;
    end
`endif
  end

  // resp_pc tracks the address of the next response that will be kept.
  always_comb begin
    fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = (imem_rvalid && !drop) ? resp_pc_q + 32'd4 : resp_pc_q;
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    discard_d  = drop ? discard_q - CNT_W'(1) : discard_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
    // Everything still in flight after this cycle belongs to the old stream.
    if (ip_redirect) begin
      state_d    = ST_FLUSH;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= imem_rdata;
        addr_q[wr_ptr_q] <= resp_pc_q;
      end
    end
  end

endmodule
